notif_tx: RTL and testbench

NOTIF_TX -- requirements
Module: notif_tx

---
 rtl/notif_tx_pkg.sv | 37 +++
 rtl/notif_tx_if.sv | 22 ++
 rtl/notif_tx_pending_reg.sv | 45 ++++
 rtl/notif_tx.sv | 164 ++++++++++++++++
 tb/tb_notif_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/notif_tx_pkg.sv
// rtl/notif_tx_pkg.sv - shared widths, frame type codes and FSM states for notif_tx.
// State CHK exists only when NOTIF_TX_CHECKSUM_EN is defined.
package notif_tx_pkg;

  localparam int DEF_UART_DATA_WIDTH         = 8;
  localparam int DEF_CONFIG_NOTIFICATION_WIDTH = 4;
  localparam int DEF_CONFIG_ERROR_WIDTH      = 4;
  localparam int DEF_VGA_NOTIFICATION_WIDTH  = 4;
  localparam int SEQ_W                       = 6;
  localparam int TYPE_W                      = 2;

  localparam logic [TYPE_W-1:0] TYPE_ERR = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_CFG = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_VGA = 2'b11;

`ifdef NOTIF_TX_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;
`endif

  // Header byte: frame type in the top two bits, rolling sequence number below.
  function automatic logic [7:0] make_hdr(input logic [TYPE_W-1:0] typ,
                                          input logic [SEQ_W-1:0] seq);
    return {typ, seq};
  endfunction

endpackage

// File: rtl/notif_tx_if.sv
// rtl/notif_tx_if.sv - TX FIFO push interface between notif_tx and the UART TX FIFO.
interface notif_tx_if #(
  parameter int UART_DATA_WIDTH = 8
) ();

  logic [UART_DATA_WIDTH-1:0] TXD_Data;
  logic                       Write;
  logic                       Full;

  modport master (
    output TXD_Data,
    output Write,
    input  Full
  );

  modport slave (
    input  TXD_Data,
    input  Write,
    output Full
  );

endinterface

// File: rtl/notif_tx_pending_reg.sv
// rtl/notif_tx_pending_reg.sv - notif_pending_reg: 1-deep pending flag plus code, set wins over clear.
module notif_pending_reg #(
  parameter int CODE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_i,
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic                  clr_i,
  output logic                  pending_o,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  overflow_o
);

  logic                  pending_q, pending_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;

  always_comb begin
    pending_d = pending_q;
    code_d    = code_q;
    if (clr_i) begin
      pending_d = 1'b0;
    end
    if (set_i) begin
      pending_d = 1'b1;
      code_d    = code_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

  assign pending_o  = pending_q;
  assign code_o     = code_q;
  // A strobe landing on the same edge as the clear refills the slot; nothing is lost.
  assign overflow_o = set_i & pending_q & ~clr_i;

endmodule

// File: rtl/notif_tx.sv
// rtl/notif_tx.sv - frames error/config/VGA notification codes into bytes for the UART TX FIFO.
// Optional NOTIF_TX_CHECKSUM_EN appends a header-XOR-payload byte to each frame.
module notif_tx
  import notif_tx_pkg::*;
#(
  parameter int UART_DATA_WIDTH           = DEF_UART_DATA_WIDTH,
  parameter int CONFIG_NOTIFICATION_WIDTH = DEF_CONFIG_NOTIFICATION_WIDTH,
  parameter int CONFIG_ERROR_WIDTH        = DEF_CONFIG_ERROR_WIDTH,
  parameter int VGA_NOTIFICATION_WIDTH    = DEF_VGA_NOTIFICATION_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  notif_tx_if.master                           tx,
  output logic                                 Busy,
  output logic                                 Overflow
);

  logic                                 err_pend, cfg_pend, vga_pend;
  logic                                 err_clr, cfg_clr, vga_clr;
  logic                                 err_ovf, cfg_ovf, vga_ovf;
  logic [CONFIG_ERROR_WIDTH-1:0]        err_code;
  logic [CONFIG_NOTIFICATION_WIDTH-1:0] cfg_code;
  logic [VGA_NOTIFICATION_WIDTH-1:0]    vga_code;

  state_t                     state_q, state_d;
  logic                       write_q, write_d;
  logic [UART_DATA_WIDTH-1:0] txd_q, txd_d;
  logic [UART_DATA_WIDTH-1:0] code_q, code_d;
  logic [TYPE_W-1:0]          type_q, type_d;
  logic [SEQ_W-1:0]           seq_q, seq_d;
  logic                       ovf_q, ovf_d;
  logic [UART_DATA_WIDTH-1:0] hdr_byte;

  notif_pending_reg #(.CODE_WIDTH(CONFIG_ERROR_WIDTH)) u_err_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (Error_Valid),
    .code_i     (Config_Error),
    .clr_i      (err_clr),
    .pending_o  (err_pend),
    .code_o     (err_code),
    .overflow_o (err_ovf)
  );

  notif_pending_reg #(.CODE_WIDTH(CONFIG_NOTIFICATION_WIDTH)) u_cfg_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (Config_Notification_Valid),
    .code_i     (Config_Notification),
    .clr_i      (cfg_clr),
    .pending_o  (cfg_pend),
    .code_o     (cfg_code),
    .overflow_o (cfg_ovf)
  );

  notif_pending_reg #(.CODE_WIDTH(VGA_NOTIFICATION_WIDTH)) u_vga_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (VGA_Notification_Valid),
    .code_i     (VGA_Notification),
    .clr_i      (vga_clr),
    .pending_o  (vga_pend),
    .code_o     (vga_code),
    .overflow_o (vga_ovf)
  );

  assign hdr_byte = UART_DATA_WIDTH'(make_hdr(type_q, seq_q));
  assign ovf_d    = ovf_q | err_ovf | cfg_ovf | vga_ovf;

  always_comb begin
    state_d = state_q;
    write_d = 1'b0;
    txd_d   = txd_q;
    code_d  = code_q;
    type_d  = type_q;
    seq_d   = seq_q;
    err_clr = 1'b0;
    cfg_clr = 1'b0;
    vga_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Fixed priority: errors first, then config, then VGA.
        if (err_pend) begin
          type_d  = TYPE_ERR;
          code_d  = UART_DATA_WIDTH'(err_code);
          err_clr = 1'b1;
          state_d = ST_HDR;
        end else if (cfg_pend) begin
          type_d  = TYPE_CFG;
          code_d  = UART_DATA_WIDTH'(cfg_code);
          cfg_clr = 1'b1;
          state_d = ST_HDR;
        end else if (vga_pend) begin
          type_d  = TYPE_VGA;
          code_d  = UART_DATA_WIDTH'(vga_code);
          vga_clr = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!tx.Full) begin
          write_d = 1'b1;
          txd_d   = hdr_byte;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!tx.Full) begin
          write_d = 1'b1;
          txd_d   = code_q;
`ifdef NOTIF_TX_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_IDLE;
          seq_d   = seq_q + 6'd1;
`endif
        end
      end
`ifdef NOTIF_TX_CHECKSUM_EN
      ST_CHK: begin
        if (!tx.Full) begin
          write_d = 1'b1;
          txd_d   = hdr_byte ^ code_q;
          state_d = ST_IDLE;
          seq_d   = seq_q + 6'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      txd_q   <= '0;
      code_q  <= '0;
      type_q  <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      txd_q   <= txd_d;
      code_q  <= code_d;
      type_q  <= type_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx.TXD_Data = txd_q;
  assign tx.Write    = write_q;
  assign Busy        = (state_q != ST_IDLE) | err_pend | cfg_pend | vga_pend;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_notif_tx.sv
// tb/tb_notif_tx.sv - directed self-checking bench for notif_tx (honours NOTIF_TX_CHECKSUM_EN).
module tb_notif_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [3:0] Config_Error;
  logic       Error_Valid;
  logic [3:0] VGA_Notification;
  logic       VGA_Notification_Valid;
  logic       Busy;
  logic       Overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  notif_tx_if #(.UART_DATA_WIDTH(8)) bus ();

  notif_tx dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .VGA_Notification          (VGA_Notification),
    .VGA_Notification_Valid    (VGA_Notification_Valid),
    .tx                        (bus),
    .Busy                      (Busy),
    .Overflow                  (Overflow)
  );

  always #5 clk = ~clk;

  // FIFO-side capture of every pushed byte, sampled shortly after the edge.
  always @(posedge clk) begin
    #2;
    if (bus.Write === 1'b1) got_q.push_back(bus.TXD_Data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_strobes();
    Error_Valid               = 1'b0;
    Config_Notification_Valid = 1'b0;
    VGA_Notification_Valid    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_strobes();
    bus.Full = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic add_frame(input logic [1:0] t, input logic [5:0] s, input logic [7:0] c);
    logic [7:0] h;
    h = {t, s};
    exp_q.push_back(h);
    exp_q.push_back(c);
`ifdef NOTIF_TX_CHECKSUM_EN
    exp_q.push_back(h ^ c);
`endif
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Full = 1'b0;
    Config_Notification = '0;
    Config_Error = '0;
    VGA_Notification = '0;
    clear_strobes();
    step(2);

    // Reset state
    check("rst_write", bus.Write, 1'b0);
    check("rst_txd", bus.TXD_Data, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_ovf", Overflow, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Single error frame, latency of two edges to the header
    Config_Error = 4'h3;
    Error_Valid  = 1'b1;
    step(1);
    clear_strobes();
    check("lat_busy", Busy, 1'b1);
    check("lat_wr_e0", bus.Write, 1'b0);
    step(1);
    check("lat_wr_e1", bus.Write, 1'b0);
    step(1);
    check("lat_hdr_wr", bus.Write, 1'b1);
    check("lat_hdr", bus.TXD_Data, 8'h80);
    step(1);
    check("lat_pay_wr", bus.Write, 1'b1);
    check("lat_pay", bus.TXD_Data, 8'h03);
`ifdef NOTIF_TX_CHECKSUM_EN
    step(1);
    check("lat_chk", bus.TXD_Data, 8'h83);
`endif
    step(1);
    check("lat_end_wr", bus.Write, 1'b0);
    check("lat_end_busy", Busy, 1'b0);

    // Three simultaneous strobes drain by priority
    do_reset();
    Config_Error = 4'h2; Error_Valid = 1'b1;
    Config_Notification = 4'h1; Config_Notification_Valid = 1'b1;
    VGA_Notification = 4'h3; VGA_Notification_Valid = 1'b1;
    step(1);
    clear_strobes();
    step(14);
    add_frame(2'b10, 6'd0, 8'h02);
    add_frame(2'b01, 6'd1, 8'h01);
    add_frame(2'b11, 6'd2, 8'h03);
    check_frames("prio");
    check("prio_ovf", Overflow, 1'b0);
    check("prio_busy", Busy, 1'b0);

    // Full held for ten cycles during payload
    do_reset();
    Config_Notification = 4'h7; Config_Notification_Valid = 1'b1;
    step(1);
    clear_strobes();
    step(2);
    check("full_hdr", bus.TXD_Data, 8'h40);
    bus.Full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("full_hold%0d", i), bus.Write, 1'b0);
    end
    check("full_txd_stable", bus.TXD_Data, 8'h40);
    check("full_busy", Busy, 1'b1);
    bus.Full = 1'b0;
    step(1);
    check("full_pay_wr", bus.Write, 1'b1);
    check("full_pay", bus.TXD_Data, 8'h07);
    step(4);
    add_frame(2'b01, 6'd0, 8'h07);
    check_frames("full");

    // Set wins over clear: strobe on the edge its slot is selected
    do_reset();
    VGA_Notification = 4'h2; VGA_Notification_Valid = 1'b1;
    step(1);
    VGA_Notification = 4'h4;
    step(1);
    clear_strobes();
    step(10);
    add_frame(2'b11, 6'd0, 8'h02);
    add_frame(2'b11, 6'd1, 8'h04);
    check_frames("setwin");
    check("setwin_ovf", Overflow, 1'b0);

    // Overwrite of a pending VGA code while busy
    do_reset();
    Config_Error = 4'h1; Error_Valid = 1'b1;
    step(1);
    clear_strobes();
    VGA_Notification = 4'h5; VGA_Notification_Valid = 1'b1;
    step(1);
    VGA_Notification = 4'h6;
    step(1);
    clear_strobes();
    check("ovf_set", Overflow, 1'b1);
    step(12);
    add_frame(2'b10, 6'd0, 8'h01);
    add_frame(2'b11, 6'd1, 8'h06);
    check_frames("ovf");
    check("ovf_sticky", Overflow, 1'b1);
    do_reset();
    check("ovf_cleared", Overflow, 1'b0);

    // Reset right after the header write abandons the frame
    Config_Error = 4'h4; Error_Valid = 1'b1;
    step(1);
    clear_strobes();
    step(2);
    check("abort_hdr_wr", bus.Write, 1'b1);
    check("abort_hdr", bus.TXD_Data, 8'h80);
    rst_n = 1'b0;
    step(1);
    check("abort_wr_rst", bus.Write, 1'b0);
    check("abort_busy_rst", Busy, 1'b0);
    rst_n = 1'b1;
    step(6);
    check("abort_count", got_q.size(), 1);
    got_q.delete();
    Config_Notification = 4'h9; Config_Notification_Valid = 1'b1;
    step(1);
    clear_strobes();
    step(8);
    add_frame(2'b01, 6'd0, 8'h09);
    check_frames("abort_next");

`ifdef NOTIF_TX_CHECKSUM_EN
    // Checksum frame bytes
    do_reset();
    Config_Notification = 4'hA; Config_Notification_Valid = 1'b1;
    step(1);
    clear_strobes();
    step(8);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h4A);
    check_frames("chk");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
